// File: rtl/crc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : crc_pkg
// Purpose  : Shared definitions for the CRC-8 link (generator and receiver):
//            polynomial, CRC width, receiver FSM state type and the
//            single-bit CRC update used by every bit-serial CRC engine.
// Revision : 1.0 - initial release
// ============================================================================
package crc_pkg;

    localparam int         CRC_W    = 8;
    localparam logic [7:0] CRC_POLY = 8'h1D;   // x^8 + x^4 + x^3 + x^2 + 1

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CRC  = 2'd2,
        STOP = 2'd3
    } crc_rx_state_t;

    // One MSB-first step: feedback is the outgoing MSB xor the incoming bit.
    function automatic logic [CRC_W-1:0] crc8_step(input logic [CRC_W-1:0] crc,
                                                   input logic             bit_in);
        logic w_fb;
        w_fb = crc[CRC_W-1] ^ bit_in;
        return {crc[CRC_W-2:0], 1'b0} ^ (w_fb ? CRC_POLY : 8'h00);
    endfunction

endpackage : crc_pkg
`default_nettype wire

// File: rtl/crc8_serial.sv
`default_nettype none
// ============================================================================
// Module   : crc8_serial
// Purpose  : Bit-serial CRC-8 register (LFSR). Clear forces the register to
//            the zero initial value; enable folds one input bit per clock.
//            Clear has priority over enable.
// Ports    : clk   in  1      rising-edge clock
//            rst   in  1      synchronous active-high reset
//            clr   in  1      load zero initial value
//            en    in  1      fold din into the CRC this cycle
//            din   in  1      serial data bit
//            crc   out CRC_W  current CRC value
// Revision : 1.0 - initial release
// ============================================================================
module crc8_serial
    import crc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [CRC_W-1:0] crc
);

    logic [CRC_W-1:0] r_crc;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_crc <= '0;
        end else if (en) begin
            r_crc <= crc8_step(r_crc, din);
        end
    end

    assign crc = r_crc;

endmodule : crc8_serial
`default_nettype wire

// File: rtl/crc_rx_checker.sv
`default_nettype none
// ============================================================================
// Module   : crc_rx_checker
// Purpose  : Serial receiver for CRC-8 protected frames. Deserialises
//            start(0) / DATA_W payload bits / 8 CRC bits / stop(1), all MSB
//            first, recomputes the CRC over the payload and reports the word
//            with pass/fail and framing status on a one-cycle valid pulse.
// Options  : CRC_RX_STATS_EN - adds err_count, a saturating count of frames
//            with a CRC mismatch or a low stop bit.
// Ports    : clk        in  1       rising-edge clock
//            reset      in  1       synchronous active-high reset
//            rxd        in  1       serial line, idles high
//            dataout    out DATA_W  last received payload
//            crcout     out 8       CRC byte received with last frame
//            valid      out 1       one-cycle pulse, frame completed
//            crc_ok     out 1       recomputed CRC matched crcout
//            frame_err  out 1       stop bit sampled low
//            err_count  out 8       error count (CRC_RX_STATS_EN only)
// Revision : 1.0 - initial release
// ============================================================================
module crc_rx_checker
    import crc_pkg::*;
#(
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rxd,
    output logic [DATA_W-1:0] dataout,
    output logic [CRC_W-1:0]  crcout,
    output logic              valid,
    output logic              crc_ok,
    output logic              frame_err
`ifdef CRC_RX_STATS_EN
    ,
    output logic [7:0]        err_count
`endif
);

    // The bit counter is 5 bits, which bounds DATA_W to at most 32.
    localparam logic [4:0] c_data_last = 5'(DATA_W - 1);
    localparam logic [4:0] c_crc_last  = 5'(CRC_W - 1);

    crc_rx_state_t     r_state;
    crc_rx_state_t     w_state_nxt;
    logic [4:0]        r_cnt;
    logic [DATA_W-1:0] r_payload;
    logic [CRC_W-1:0]  r_rxcrc;
    logic [CRC_W-1:0]  w_calc;

    logic w_cnt_clr;
    logic w_cnt_inc;
    logic w_crc_clr;
    logic w_crc_en;
    logic w_pay_shift;
    logic w_rxcrc_shift;
    logic w_done;
    logic w_match;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and datapath controls
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_clr     = 1'b0;
        w_cnt_inc     = 1'b0;
        w_crc_clr     = 1'b0;
        w_crc_en      = 1'b0;
        w_pay_shift   = 1'b0;
        w_rxcrc_shift = 1'b0;
        w_done        = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!rxd) begin
                    w_state_nxt = DATA;
                    w_cnt_clr   = 1'b1;
                    w_crc_clr   = 1'b1;
                end
            end
            DATA: begin
                w_pay_shift = 1'b1;
                w_crc_en    = 1'b1;
                if (r_cnt == c_data_last) begin
                    w_state_nxt = CRC;
                    w_cnt_clr   = 1'b1;
                end else begin
                    w_cnt_inc   = 1'b1;
                end
            end
            CRC: begin
                w_rxcrc_shift = 1'b1;
                if (r_cnt == c_crc_last) begin
                    w_state_nxt = STOP;
                    w_cnt_clr   = 1'b1;
                end else begin
                    w_cnt_inc   = 1'b1;
                end
            end
            STOP: begin
                // A low stop bit is only a framing error; the next start is
                // looked for from the following edge on.
                w_state_nxt = IDLE;
                w_cnt_clr   = 1'b1;
                w_done      = 1'b1;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Bit counter: counts only inside DATA and CRC, cleared on entry
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset || w_cnt_clr) begin
            r_cnt <= '0;
        end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + 5'd1;
        end
    end

    // ------------------------------------------------------------------
    // Shift registers for the payload and the received CRC byte
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_payload <= '0;
            r_rxcrc   <= '0;
        end else begin
            if (w_pay_shift) begin
                r_payload <= {r_payload[DATA_W-2:0], rxd};
            end
            if (w_rxcrc_shift) begin
                r_rxcrc <= {r_rxcrc[CRC_W-2:0], rxd};
            end
        end
    end

    // ------------------------------------------------------------------
    // CRC recomputed over the payload bits only
    // ------------------------------------------------------------------
    crc8_serial u_calc_crc (
        .clk (clk),
        .rst (reset),
        .clr (w_crc_clr),
        .en  (w_crc_en),
        .din (rxd),
        .crc (w_calc)
    );

    assign w_match = (r_rxcrc == w_calc);

    // ------------------------------------------------------------------
    // Result registers, updated by the stop-bit edge and held otherwise
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            dataout   <= '0;
            crcout    <= '0;
            crc_ok    <= 1'b0;
            frame_err <= 1'b0;
            valid     <= 1'b0;
        end else begin
            valid <= w_done;
            if (w_done) begin
                dataout   <= r_payload;
                crcout    <= r_rxcrc;
                crc_ok    <= w_match;
                frame_err <= ~rxd;
            end
        end
    end

`ifdef CRC_RX_STATS_EN
    // ------------------------------------------------------------------
    // Saturating error statistics
    // ------------------------------------------------------------------
    logic [7:0] r_err_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_count <= '0;
        end else if (w_done && (!w_match || !rxd) && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = r_err_count;
`endif

endmodule : crc_rx_checker
`default_nettype wire

// File: tb/tb_crc_rx_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_crc_rx_checker
// Purpose  : Self-checking bench for crc_rx_checker: directed table of
//            frames, multi-cycle corner sequences (idle, back-to-back,
//            mid-frame reset) and randomized frames against a CRC model
//            computed by polynomial long division.
// Revision : 1.0 - initial release
// ============================================================================
module tb_crc_rx_checker;

    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          rxd;
    logic [DW-1:0] dataout;
    logic [7:0]    crcout;
    logic          valid;
    logic          crc_ok;
    logic          frame_err;
`ifdef CRC_RX_STATS_EN
    logic [7:0]    err_count;
`endif

    crc_rx_checker #(.DATA_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .rxd       (rxd),
        .dataout   (dataout),
        .crcout    (crcout),
        .valid     (valid),
        .crc_ok    (crc_ok),
        .frame_err (frame_err)
`ifdef CRC_RX_STATS_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_valid = 0;
    int vcyc[$];
    int frames_sent = 0;
    int exp_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            n_valid = n_valid + 1;
            vcyc.push_back(cyc);
        end
    end

    typedef struct {
        logic [DW-1:0] payload;
        logic [7:0]    crc;
        logic          stop;
        logic          exp_ok;
        logic          exp_ferr;
    } vec_t;

    vec_t vecs[4];

    // Remainder of payload * x^8 divided by x^8+x^4+x^3+x^2+1.
    function automatic logic [7:0] ref_crc(input logic [DW-1:0] p);
        logic [DW+7:0] m;
        m = {p, 8'h00};
        for (int i = DW + 7; i >= 8; i--) begin
            if (m[i]) m = m ^ ((DW+8)'(9'h11D) << (i - 8));
        end
        return m[7:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one bit, let one rising edge sample it, return just after it.
    task automatic send_bit(input logic b);
        rxd = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [DW-1:0] p, input logic [7:0] c, input logic stop);
        send_bit(1'b0);
        for (int i = DW - 1; i >= 0; i--) send_bit(p[i]);
        for (int i = 7; i >= 0; i--) send_bit(c[i]);
        send_bit(stop);
        frames_sent = frames_sent + 1;
    endtask

    // Called right after the stop-bit edge: the result cycle is visible now.
    task automatic check_result(input string tag, input logic [DW-1:0] p, input logic [7:0] c,
                                input logic ok, input logic ferr);
        check({tag, ".valid"},     32'(valid),     32'd1);
        check({tag, ".dataout"},   32'(dataout),   32'(p));
        check({tag, ".crcout"},    32'(crcout),    32'(c));
        check({tag, ".crc_ok"},    32'(crc_ok),    32'(ok));
        check({tag, ".frame_err"}, 32'(frame_err), 32'(ferr));
        if (!ok || ferr) begin
            if (exp_err < 255) exp_err = exp_err + 1;
        end
`ifdef CRC_RX_STATS_EN
        check({tag, ".err_count"}, 32'(err_count), 32'(exp_err));
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rxd   = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_err = 0;
    endtask

    initial begin
        int nv0;
        logic [DW-1:0] p;
        logic [7:0]    c;
        logic          s;
        logic          ok;

        vecs[0] = '{12'h001, 8'h1D, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{12'h002, 8'h1D, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{12'h800, 8'h5A, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{12'h002, 8'h3A, 1'b1, 1'b1, 1'b0};

        reset = 1'b1;
        rxd   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state and idle line.
        check("rst.valid",     32'(valid),     32'd0);
        check("rst.dataout",   32'(dataout),   32'd0);
        check("rst.crcout",    32'(crcout),    32'd0);
        check("rst.crc_ok",    32'(crc_ok),    32'd0);
        check("rst.frame_err", 32'(frame_err), 32'd0);
`ifdef CRC_RX_STATS_EN
        check("rst.err_count", 32'(err_count), 32'd0);
`endif
        repeat (50) send_bit(1'b1);
        check("idle.no_valid", 32'(n_valid), 32'd0);
        check("idle.dataout",  32'(dataout), 32'd0);
        check("idle.crc_ok",   32'(crc_ok),  32'd0);

        // Model sanity against the known CRC values of the table.
        check("model.crc001", 32'(ref_crc(12'h001)), 32'h1D);
        check("model.crc800", 32'(ref_crc(12'h800)), 32'h5A);

        // Directed table.
        for (int i = 0; i < 4; i++) begin
            send_frame(vecs[i].payload, vecs[i].crc, vecs[i].stop);
            check_result($sformatf("vec%0d", i), vecs[i].payload, vecs[i].crc,
                         vecs[i].exp_ok, vecs[i].exp_ferr);
            send_bit(1'b1);
            check($sformatf("vec%0d.valid_drop", i), 32'(valid), 32'd0);
            check($sformatf("vec%0d.hold", i), 32'(dataout), 32'(vecs[i].payload));
        end

        // Back-to-back frames with no idle gap.
        nv0 = n_valid;
        send_frame(12'h001, 8'h1D, 1'b1);
        check_result("b2b0", 12'h001, 8'h1D, 1'b1, 1'b0);
        send_frame(12'h002, 8'h3A, 1'b1);
        check_result("b2b1", 12'h002, 8'h3A, 1'b1, 1'b0);
        send_bit(1'b1);
        check("b2b.pulses", 32'(n_valid - nv0), 32'd2);
        if (vcyc.size() >= 2)
            check("b2b.spacing", 32'(vcyc[vcyc.size()-1] - vcyc[vcyc.size()-2]), 32'd22);

        // Reset at payload bit 5, then a complete frame.
        nv0 = n_valid;
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        do_reset();
        check("midrst.dataout", 32'(dataout), 32'd0);
        send_frame(12'h002, 8'h3A, 1'b1);
        frames_sent = frames_sent - 1;  // aborted frame above never counted
        frames_sent = frames_sent + 1;
        check_result("midrst", 12'h002, 8'h3A, 1'b1, 1'b0);
        send_bit(1'b1);
        check("midrst.pulses", 32'(n_valid - nv0), 32'd1);

        // Randomized frames with random gaps, bad CRCs and bad stop bits.
        for (int n = 0; n < 60; n++) begin
            p = DW'($urandom_range(0, (1 << DW) - 1));
            c = ref_crc(p);
            if ($urandom_range(0, 3) == 0) c = 8'($urandom);
            s = ($urandom_range(0, 4) != 0);
            ok = (c == ref_crc(p));
            send_frame(p, c, s);
            check_result($sformatf("rnd%0d", n), p, c, ok, ~s);
            repeat ($urandom_range(0, 2)) send_bit(1'b1);
        end
        send_bit(1'b1);
        send_bit(1'b1);

        check("total.pulses", 32'(n_valid), 32'(frames_sent));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_crc_rx_checker
`default_nettype wire
